// File: rtl/unidade_controle_if.sv
// Instruction fetch channel between the control unit and the instruction source.
interface unidade_controle_if;
   logic [11:0] pc;
   logic        instr_ready;
   logic        instr_valid;
   logic [15:0] instr;

   modport master (output pc, output instr_ready, input instr_valid, input instr);
   modport slave  (input pc, input instr_ready, output instr_valid, output instr);
endinterface

// File: rtl/unidade_controle.sv
// Multi-cycle accumulator control unit: FETCH/DECODE/EXEC/WRITE/HALT, one instruction retired before the next fetch.
// Latency per instruction: ALU 2+EXEC_CYCLES, LOAD 2, others 1; instr_ready is only high in FETCH.
module unidade_controle #(
   parameter int EXEC_CYCLES = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   unidade_controle_if.master        fetch,
   output logic [15:0]               imm,
   output logic                      mbr_load,
   output logic [3:0]                ula_sel,
   output logic                      ula_re,
   input  logic                      flagz,
   input  logic                      flagn,
   output logic                      ac_sel,
   output logic                      ac_load,
   output logic                      zf,
   output logic                      nf,
   output logic                      halted,
   output logic                      div_err,
   output logic                      ill_op
);

   localparam logic [3:0] OP_LOAD = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_DIV  = 4'h5;
   localparam logic [3:0] OP_NOT  = 4'h8;
   localparam logic [3:0] OP_JZ   = 4'h9;
   localparam logic [3:0] OP_JN   = 4'hA;
   localparam logic [3:0] OP_JMP  = 4'hB;
   localparam logic [3:0] OP_HALT = 4'hF;
   localparam logic [3:0] CNT_LAST = 4'(EXEC_CYCLES - 1);

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, WRITE, HALT} state_t;

   state_t      state, state_nxt;
   logic [11:0] pc;
   logic [15:0] ir;
   logic [3:0]  cnt;
   logic [3:0]  opcode;
   logic [11:0] operand;
   logic        is_alu, is_load, is_rsv, div_zero, jump_taken, exec_done, accept, rdy;

   assign opcode     = ir[15:12];
   assign operand    = ir[11:0];
   assign imm        = {{4{ir[11]}}, ir[11:0]};
   assign is_alu     = opcode inside {[OP_ADD:OP_NOT]};
   assign is_load    = (opcode == OP_LOAD);
   assign is_rsv     = opcode inside {[4'hC:4'hE]};
   assign div_zero   = (opcode == OP_DIV) && (operand == 12'h000);
   // Branches look at the flags latched by earlier instructions only.
   assign jump_taken = ((opcode == OP_JZ) && zf) || ((opcode == OP_JN) && nf) || (opcode == OP_JMP);
   assign exec_done  = (cnt == CNT_LAST);
   assign accept     = rdy && fetch.instr_valid;
   assign halted     = (state == HALT);
   assign fetch.pc   = pc;
   assign fetch.instr_ready = rdy;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= FETCH;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      rdy       = 1'b0;
      mbr_load  = 1'b0;
      ula_sel   = 4'h0;
      ula_re    = 1'b0;
      ac_sel    = 1'b0;
      ac_load   = 1'b0;
      case (state)
         FETCH: begin
            rdy = 1'b1;
            if (fetch.instr_valid) state_nxt = DECODE;
         end
         DECODE: begin
            mbr_load = is_alu || is_load;
            if (is_alu)                 state_nxt = div_zero ? FETCH : EXEC;
            else if (is_load)           state_nxt = WRITE;
            else if (opcode == OP_HALT) state_nxt = HALT;
            else                        state_nxt = FETCH;
         end
         EXEC: begin
            ula_sel = opcode;
            ula_re  = 1'b1;
            if (exec_done) state_nxt = WRITE;
         end
         WRITE: begin
            if (is_alu) begin
               ula_sel = opcode;
               ula_re  = 1'b1;
            end else begin
               ac_sel  = 1'b1;
            end
            ac_load   = 1'b1;
            state_nxt = FETCH;
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc      <= 12'h000;
         ir      <= 16'h0000;
         cnt     <= 4'h0;
         zf      <= 1'b1;
         nf      <= 1'b0;
         div_err <= 1'b0;
         ill_op  <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (accept) begin
                  ir <= fetch.instr;
                  pc <= pc + 12'd1;
               end
            end
            DECODE: begin
               if (is_alu && div_zero) div_err <= 1'b1;
               if (is_rsv)             ill_op  <= 1'b1;
               if (jump_taken)         pc      <= operand;
            end
            EXEC: cnt <= exec_done ? 4'h0 : cnt + 4'd1;
            WRITE: begin
               if (is_load) begin
                  zf <= (imm == 16'h0000);
                  nf <= imm[15];
               end else begin
                  zf <= flagz;
                  nf <= flagn;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
